// File: rtl/mux_rr_scheduler_if.sv
// Handshake bundle between the eight requesters and the round-robin mux scheduler.
// The scheduler takes the slave view; the requester side (or a bench) takes the master view.
interface mux_rr_scheduler_if;
  logic [7:0] Req;
  logic       Done;
  logic [2:0] Selector;
  logic [7:0] Grant;
  logic       Busy;

  modport master (output Req, Done, input Selector, Grant, Busy);
  modport slave  (input Req, Done, output Selector, Grant, Busy);
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler that owns the select input of an 8-to-1 bit mux.
// Grants end on Done, on a dropped request or when the beat budget runs out.
module mux_rr_scheduler #(
  parameter int MaxBeats = 4
) (
  input logic          clk,
  input logic          reset,
  mux_rr_scheduler_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LastBeat = 8'(MaxBeats - 1);

  state_t     state, stateNext;
  logic [2:0] last, lastNext;
  logic [2:0] selNext;
  logic [7:0] count, countNext;
  logic [7:0] grantNext;
  logic       busyNext;
  logic       releaseNow;
  logic [2:0] searchFrom;
  logic [3:0] pick;

  // Searches from+1 upward with wrap; 'from' itself is the last candidate,
  // so a lone requester can be re-granted. Bit 3 flags that a winner exists.
  function automatic logic [3:0] arbitrate(input logic [7:0] req, input logic [2:0] from);
    logic [3:0] result;
    logic [2:0] idx;
    result = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = from + 3'(k);
      if (!result[3] && req[idx]) result = {1'b1, idx};
    end
    return result;
  endfunction

  // Registered state and outputs, so nothing combinational reaches the mux select.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last         <= 3'd7;
      count        <= '0;
      bus.Selector <= '0;
      bus.Grant    <= '0;
      bus.Busy     <= 1'b0;
    end else begin
      state        <= stateNext;
      last         <= lastNext;
      count        <= countNext;
      bus.Selector <= selNext;
      bus.Grant    <= grantNext;
      bus.Busy     <= busyNext;
    end
  end

  // On release the current owner becomes the new search origin before arbitrating,
  // which lets the next owner take over at the same edge.
  always_comb begin
    stateNext  = state;
    lastNext   = last;
    countNext  = count;
    selNext    = bus.Selector;
    grantNext  = bus.Grant;
    busyNext   = bus.Busy;
    releaseNow = 1'b0;
    searchFrom = last;

    if (state == GRANT)
      releaseNow = bus.Done || !bus.Req[bus.Selector] || (count == LastBeat);
    if (releaseNow)
      searchFrom = bus.Selector;
    pick = arbitrate(bus.Req, searchFrom);

    case (state)
      IDLE: begin
        if (pick[3]) begin
          stateNext = GRANT;
          selNext   = pick[2:0];
          grantNext = 8'h01 << pick[2:0];
          busyNext  = 1'b1;
          countNext = '0;
        end
      end
      GRANT: begin
        if (!releaseNow) begin
          countNext = count + 8'd1;
        end else begin
          lastNext  = bus.Selector;
          countNext = '0;
          if (pick[3]) begin
            selNext   = pick[2:0];
            grantNext = 8'h01 << pick[2:0];
            busyNext  = 1'b1;
          end else begin
            stateNext = IDLE;
            grantNext = '0;
            busyNext  = 1'b0;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler: a vector table on a MaxBeats=4 instance,
// plus hand sequences on MaxBeats=2 and MaxBeats=1 instances.
module tb_mux_rr_scheduler;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] expGrant;
    logic [2:0] expSel;
    logic       expBusy;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t vecs[$];

  mux_rr_scheduler_if bus4 ();
  mux_rr_scheduler_if bus2 ();
  mux_rr_scheduler_if bus1 ();

  mux_rr_scheduler #(.MaxBeats(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  mux_rr_scheduler #(.MaxBeats(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  mux_rr_scheduler #(.MaxBeats(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic rst, input logic [7:0] req, input logic done,
                        input logic [7:0] g, input logic [2:0] s, input logic b);
    vec_t v;
    v.rst = rst; v.req = req; v.done = done;
    v.expGrant = g; v.expSel = s; v.expBusy = b;
    vecs.push_back(v);
  endtask

  // Drives one instance's inputs plus the shared reset, then samples 1 time unit after the edge.
  task automatic applyStimulus(input int which, input logic rst, input logic [7:0] req, input logic done);
    reset = rst;
    case (which)
      4: begin bus4.Req = req; bus4.Done = done; end
      2: begin bus2.Req = req; bus2.Done = done; end
      default: begin bus1.Req = req; bus1.Done = done; end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name,
                             input logic [7:0] actG, input logic [2:0] actS, input logic actB,
                             input logic [7:0] expG, input logic [2:0] expS, input logic expB);
    checks++;
    if (actG !== expG) begin
      failures++;
      $display("[TB] FAIL %s Grant got=%h want=%h", name, actG, expG);
    end
    checks++;
    if (actS !== expS) begin
      failures++;
      $display("[TB] FAIL %s Selector got=%0d want=%0d", name, actS, expS);
    end
    checks++;
    if (actB !== expB) begin
      failures++;
      $display("[TB] FAIL %s Busy got=%b want=%b", name, actB, expB);
    end
  endtask

  initial begin
    logic [2:0] sel;
    logic [7:0] g;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus4.Req = '0; bus4.Done = 1'b0;
    bus2.Req = '0; bus2.Done = 1'b0;
    bus1.Req = '0; bus1.Done = 1'b0;

    //      rst  req    done grant  sel   busy
    addVec(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    addVec(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    addVec(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1);
    addVec(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1);
    addVec(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1);
    addVec(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1);
    addVec(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1);
    addVec(1'b0, 8'h03, 1'b0, 8'h01, 3'd0, 1'b1);
    addVec(1'b0, 8'h03, 1'b0, 8'h01, 3'd0, 1'b1);
    addVec(1'b0, 8'h03, 1'b0, 8'h01, 3'd0, 1'b1);
    addVec(1'b0, 8'h03, 1'b0, 8'h02, 3'd1, 1'b1);
    addVec(1'b0, 8'h03, 1'b1, 8'h01, 3'd0, 1'b1);
    addVec(1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1);
    addVec(1'b0, 8'h24, 1'b0, 8'h04, 3'd2, 1'b1);
    addVec(1'b0, 8'h24, 1'b1, 8'h20, 3'd5, 1'b1);
    addVec(1'b0, 8'h24, 1'b0, 8'h20, 3'd5, 1'b1);
    addVec(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1);
    addVec(1'b0, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0);
    addVec(1'b0, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0);
    addVec(1'b0, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0);
    addVec(1'b0, 8'hC0, 1'b0, 8'h40, 3'd6, 1'b1);
    addVec(1'b0, 8'hC0, 1'b0, 8'h40, 3'd6, 1'b1);
    addVec(1'b0, 8'hC0, 1'b0, 8'h40, 3'd6, 1'b1);
    addVec(1'b0, 8'hC0, 1'b0, 8'h40, 3'd6, 1'b1);
    addVec(1'b0, 8'hC0, 1'b0, 8'h80, 3'd7, 1'b1);
    addVec(1'b1, 8'hC0, 1'b0, 8'h00, 3'd0, 1'b0);
    addVec(1'b0, 8'hC0, 1'b0, 8'h40, 3'd6, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(4, vecs[i].rst, vecs[i].req, vecs[i].done);
      checkOutput($sformatf("mb4_vec%0d", i), bus4.Grant, bus4.Selector, bus4.Busy,
                  vecs[i].expGrant, vecs[i].expSel, vecs[i].expBusy);
    end
    applyStimulus(4, 1'b0, 8'h00, 1'b0);

    // All eight requesting with a two-beat budget: each channel in turn for two cycles.
    applyStimulus(2, 1'b1, 8'h00, 1'b0);
    checkOutput("mb2_reset", bus2.Grant, bus2.Selector, bus2.Busy, 8'h00, 3'd0, 1'b0);
    for (int k = 0; k <= 16; k++) begin
      applyStimulus(2, 1'b0, 8'hFF, 1'b0);
      sel = 3'((k / 2) % 8);
      g   = 8'h01 << sel;
      checkOutput($sformatf("mb2_rot%0d", k), bus2.Grant, bus2.Selector, bus2.Busy, g, sel, 1'b1);
    end
    applyStimulus(2, 1'b0, 8'h00, 1'b0);

    // Single-beat budget alternates between channels 0 and 7, with and without Done.
    applyStimulus(1, 1'b1, 8'h00, 1'b0);
    checkOutput("mb1_reset", bus1.Grant, bus1.Selector, bus1.Busy, 8'h00, 3'd0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, 1'b0, 8'h81, (k >= 6) ? 1'b1 : 1'b0);
      sel = (k % 2 == 0) ? 3'd0 : 3'd7;
      g   = (k % 2 == 0) ? 8'h01 : 8'h80;
      checkOutput($sformatf("mb1_alt%0d", k), bus1.Grant, bus1.Selector, bus1.Busy, g, sel, 1'b1);
    end
    applyStimulus(1, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
